// File: rtl/mc_loader.sv
// mc_loader: framed byte-stream program loader. Assembles little-endian bytes into 32-bit
// words, writes them through a single-word memory port, verifies an XOR checksum and holds
// the CPU in reset until a complete, verified image is in memory.
module mc_loader #(
  parameter int unsigned AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  input  logic          i_reload,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic          o_cpu_rstn,
  output logic          o_done,
  output logic          o_err
);

  typedef enum logic [2:0] {
    StCnt0,
    StCnt1,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  localparam int unsigned MaxWords = 1 << AW;

  state_e        r_state;
  logic [7:0]    r_cnt_lo;
  logic [AW:0]   r_nwords;   // one extra bit so N = 2**AW is representable
  logic [AW:0]   r_widx;
  logic [1:0]    r_lane;
  logic [7:0]    r_acc;
  logic [23:0]   r_word;     // lanes 0..2 of the word being assembled
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_cpu_rstn;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic [15:0]   w_count;
  logic          w_too_big;
  logic          w_last_word;

  // Ready is a pure state decode: never back-pressure while a frame is in progress.
  assign o_rx_ready  = (r_state == StCnt0) || (r_state == StCnt1) ||
                       (r_state == StData) || (r_state == StChk);
  assign w_accept    = i_rx_valid && o_rx_ready;
  assign w_count     = {i_rx_data, r_cnt_lo};
  assign w_too_big   = 32'(w_count) > MaxWords;
  assign w_last_word = (r_widx + 1'b1) == r_nwords;

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_rstn  = r_cpu_rstn;
  assign o_done      = r_done;
  assign o_err       = r_err;

  // Loader FSM with registered memory-port and status outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= StCnt0;
      r_cnt_lo    <= '0;
      r_nwords    <= '0;
      r_widx      <= '0;
      r_lane      <= '0;
      r_acc       <= '0;
      r_word      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rstn  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        StCnt0: begin
          if (w_accept) begin
            r_cnt_lo <= i_rx_data;
            r_state  <= StCnt1;
          end
        end
        StCnt1: begin
          if (w_accept) begin
            r_nwords <= w_count[AW:0];
            if (w_too_big) begin
              r_err   <= 1'b1;
              r_state <= StErr;
            end else if (w_count == 16'd0) begin
              r_state <= StChk;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_accept) begin
            r_acc  <= r_acc ^ i_rx_data;
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_word[7:0]   <= i_rx_data;
              2'd1: r_word[15:8]  <= i_rx_data;
              2'd2: r_word[23:16] <= i_rx_data;
              default: begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_widx[AW-1:0];
                r_mem_wdata <= {i_rx_data, r_word};
                r_widx      <= r_widx + 1'b1;
                if (w_last_word) begin
                  r_state <= StChk;
                end
              end
            endcase
          end
        end
        StChk: begin
          if (w_accept) begin
            if (i_rx_data == r_acc) begin
              r_done     <= 1'b1;
              r_cpu_rstn <= 1'b1;
              r_state    <= StDone;
            end else begin
              r_err   <= 1'b1;
              r_state <= StErr;
            end
          end
        end
        StDone, StErr: begin
          if (i_reload) begin
            r_state    <= StCnt0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_rstn <= 1'b0;
            r_widx     <= '0;
            r_lane     <= '0;
            r_acc      <= '0;
          end
        end
        default: r_state <= StCnt0;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_loader.sv
// tb_mc_loader: scoreboard bench for mc_loader. Expected memory writes are queued when a
// frame is driven and popped as mem_we pulses appear; status outputs are checked inline.
module tb_mc_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          reload;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rstn;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  exp_w;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_wr  = 0;

  always #5 clk = ~clk;

  mc_loader #(.AW(AW)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .i_reload   (reload),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_cpu_rstn (cpu_rstn),
    .o_done     (done),
    .o_err      (err)
  );

  // Advance one cycle, sample 1 time unit after the edge and retire any write seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      n_wr++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== {exp_w.addr, exp_w.data}) begin
          n_err++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, exp_w.addr, exp_w.data);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 3));
      send(bytes[i]);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reload   = 1'b0;
    rstn     = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    n_wr = 0;
    exp_q.delete();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic push_good();
    exp_q.push_back('{addr: 10'd0, data: 32'h2008_0005});
    exp_q.push_back('{addr: 10'd1, data: 32'h0008_4042});
  endtask

  task automatic test_reset();
    rx_data = 8'h00;
    do_reset();
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, cpu_rstn, done, err, rx_ready} !==
        {1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b addr=%0d wd=%h crst=%b done=%b err=%b rdy=%b, required 0 0 0 0 0 0 1",
               mem_we, mem_addr, mem_wdata, cpu_rstn, done, err, rx_ready);
    end
  endtask

  // Good image, optionally with random valid gaps.
  task automatic test_good(input bit gaps);
    logic [7:0] body[$] = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
                            8'h42, 8'h40, 8'h08, 8'h00};
    push_good();
    send_frame(body, gaps);
    if (gaps) idle(2);
    n_cmp++;
    if ({cpu_rstn, done, rx_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL good_pre_chk: got crst=%b done=%b rdy=%b, required 0 0 1",
               cpu_rstn, done, rx_ready);
    end
    send(8'h27);
    rx_valid = 1'b0;
    n_cmp++;
    if ({done, cpu_rstn, err, rx_ready} !== 4'b1100) begin
      n_err++;
      $display("FAIL good_done: got done=%b crst=%b err=%b rdy=%b, required 1 1 0 0",
               done, cpu_rstn, err, rx_ready);
    end
    n_cmp++;
    if (n_wr !== 2 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL good_writes: got %0d writes, %0d pending, required 2 writes 0 pending",
               n_wr, exp_q.size());
    end
  endtask

  task automatic test_reload();
    logic [7:0] f[$] = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    pulse_reload();
    n_cmp++;
    if ({cpu_rstn, done, err, rx_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reload_clear: got crst=%b done=%b err=%b rdy=%b, required 0 0 0 1",
               cpu_rstn, done, err, rx_ready);
    end
    n_wr = 0;
    exp_q.push_back('{addr: 10'd0, data: 32'h4433_2211});
    send_frame(f, 1'b0);
    n_cmp++;
    if ({done, cpu_rstn, err, n_wr, exp_q.size()} !== {3'b110, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL reload_load: got done=%b crst=%b err=%b writes=%0d pending=%0d, required 1 1 0 1 0",
               done, cpu_rstn, err, n_wr, exp_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f[$] = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
                         8'h42, 8'h40, 8'h08, 8'h00, 8'h26};
    do_reset();
    push_good();
    send_frame(f, 1'b0);
    n_cmp++;
    if ({err, done, cpu_rstn, rx_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL bad_chk_status: got err=%b done=%b crst=%b rdy=%b, required 1 0 0 0",
               err, done, cpu_rstn, rx_ready);
    end
    n_cmp++;
    if (n_wr !== 2 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL bad_chk_writes: got %0d writes, required 2", n_wr);
    end
    // Reload out of ERR.
    pulse_reload();
    n_cmp++;
    if ({err, done, cpu_rstn, rx_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL err_reload: got err=%b done=%b crst=%b rdy=%b, required 0 0 0 1",
               err, done, cpu_rstn, rx_ready);
    end
  endtask

  task automatic test_empty();
    logic [7:0] ok[$]  = '{8'h00, 8'h00, 8'h00};
    logic [7:0] bad[$] = '{8'h00, 8'h00, 8'h01};
    do_reset();
    send_frame(ok, 1'b0);
    n_cmp++;
    if ({done, cpu_rstn, err, n_wr} !== {3'b110, 32'd0}) begin
      n_err++;
      $display("FAIL empty_ok: got done=%b crst=%b err=%b writes=%0d, required 1 1 0 0",
               done, cpu_rstn, err, n_wr);
    end
    do_reset();
    send_frame(bad, 1'b0);
    n_cmp++;
    if ({done, cpu_rstn, err, n_wr} !== {3'b001, 32'd0}) begin
      n_err++;
      $display("FAIL empty_bad: got done=%b crst=%b err=%b writes=%0d, required 0 0 1 0",
               done, cpu_rstn, err, n_wr);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] tail[$] = '{8'h05, 8'h00, 8'h08, 8'h20, 8'h05, 8'h00, 8'h08, 8'h20};
    do_reset();
    send(8'h01);
    send(8'h04);
    n_cmp++;
    if ({err, rx_ready, cpu_rstn} !== 3'b100) begin
      n_err++;
      $display("FAIL overflow_edge: got err=%b rdy=%b crst=%b, required 1 0 0",
               err, rx_ready, cpu_rstn);
    end
    send_frame(tail, 1'b0);
    idle(2);
    n_cmp++;
    if ({err, done, n_wr} !== {2'b10, 32'd0}) begin
      n_err++;
      $display("FAIL overflow_after: got err=%b done=%b writes=%0d, required 1 0 0",
               err, done, n_wr);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] part[$] = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08};
    // Start from DONE with a non-zero write-data register left over.
    pulse_reload();
    send_frame(part, 1'b0);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, cpu_rstn, done, err, rx_ready} !==
        {1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset: got we=%b addr=%0d wd=%h crst=%b done=%b err=%b rdy=%b, required 0 0 0 0 0 0 1",
               mem_wdata === 32'd0 ? mem_we : mem_we, mem_addr, mem_wdata, cpu_rstn, done,
               err, rx_ready);
    end
    do_reset();
    test_good(1'b0);
  endtask

  initial begin
    rstn     = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;
    test_reset();
    test_good(1'b0);
    test_reload();
    test_bad_checksum();
    test_empty();
    test_overflow();
    do_reset();
    test_good(1'b1);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_loader.md
# mc_loader

Byte-stream program loader for the multi-cycle computer's unified instruction/data memory. It receives a framed little-endian byte stream over a valid/ready interface and assembles it into 32-bit words. Each word is written into memory through a single-word write port. The CPU is held in reset until a complete, checksum-verified image has been written. This block is the hardware writer side of the memory that the CPU reads at run time.

## Interface
- AW, 10, memory word-address width; the maximum image size is 2**AW words.
- clk  in  1  system clock, all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle. A byte is consumed on a rising edge where rx_valid && rx_ready.
- reload  in  1  single-cycle pulse that restarts loading. It is honoured only in DONE or ERR.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  AW  word index, i.e. the memory word address (not a byte address).
- mem_wdata  out  32  word to write.
- cpu_rstn  out  1  active-low reset to the CPU, held low until the load succeeds.
- done  out  1  image loaded and verified.
- err  out  1  load failed.

## Operation
- Frame format, in order:
  - CNT_LO, CNT_HI: the 16-bit word count N.
  - 4*N payload bytes, little-endian within each word.
  - One checksum byte equal to the XOR of all payload bytes. The count bytes are excluded from the checksum.
- States and transitions:
  - CNT0: accept CNT_LO, then go to CNT1.
  - CNT1: accept CNT_HI.
    - If N > 2**AW, go to ERR.
    - If N == 0, go to CHK.
    - Otherwise go to DATA.
  - DATA: accept payload bytes. A 2-bit byte counter (0..3) selects the byte lane; byte k goes to bits [8k+7:8k]. The running XOR accumulator updates on each accepted byte. On lane 3, write the assembled word to word index w (0..N-1). After word N-1, go to CHK.
  - CHK: accept one byte. If it equals the accumulator, go to DONE; otherwise go to ERR.
  - DONE: done=1, cpu_rstn=1, rx_ready=0. A reload pulse goes to CNT0.
  - ERR: err=1, cpu_rstn=0, rx_ready=0. A reload pulse goes to CNT0. Otherwise ERR is left only by reset.
- Reload behaviour: entering CNT0 via reload clears done, err, cpu_rstn, the word index, the lane counter and the accumulator.
- rx_ready is decoded from state: it is 1 in CNT0, CNT1, DATA and CHK, and 0 in DONE and ERR. The loader never back-pressures mid-frame. Bytes are not consumed while rstn=0.
- Gaps in rx_valid are allowed anywhere. No timeout.
- reload in CNT0..CHK is ignored.
- Word index width is AW+1 internally, so that N = 2**AW is legal. The top word is written at index 2**AW-1.

## Timing
- Reset (rstn low, asynchronous) forces:
  - state = CNT0
  - mem_we = 0, mem_addr = 0, mem_wdata = 0
  - cpu_rstn = 0, done = 0, err = 0
  - accumulator = 0, word index = 0, lane = 0
  - rx_ready = 1 (decoded from CNT0)
- A reset mid-frame discards the partial image. The next byte accepted is treated as CNT_LO.
- Write timing: the lane-3 byte is accepted at edge t. mem_we, mem_addr and mem_wdata are registered at t, so they are visible for exactly the cycle following t. mem_we returns to 0 at edge t+1 unless another word completes at t+1.
- Back-to-back words with rx_valid held high produce one mem_we every 4 cycles.
- Checksum byte accepted at edge t:
  - On match: done and cpu_rstn rise at t.
  - On mismatch: err rises at t.
  - The last mem_we strictly precedes cpu_rstn rising.
- Count overflow: err rises on the edge that accepts CNT_HI. No mem_we is ever issued.
- reload sampled at edge t in DONE or ERR: at t the state becomes CNT0, cpu_rstn becomes 0, done becomes 0 and err becomes 0.

## Test plan
- Good image, AW=10, with rx_valid held high:
  - Stimulus: bytes 02 00 | 05 00 08 20 | 42 40 08 00 | 27.
  - Required: mem_we exactly twice, at addr 0 with data 0x20080005 and at addr 1 with data 0x00084042.
  - Then done=1 and cpu_rstn=1 the cycle after byte 27 is accepted; rx_ready=0.
- Bad checksum: the same stream ending in 26 instead of 27 -> both writes occur, then err=1, done=0, cpu_rstn stays 0, rx_ready=0.
- Empty image: bytes 00 00 00 -> no mem_we, done=1, cpu_rstn=1. Bytes 00 00 01 instead -> err=1.
- Count overflow, AW=10: bytes 01 04 (N=0x0401) -> err=1 on the CNT_HI edge, no mem_we, subsequent bytes ignored.
- Gaps and mid-frame reset:
  - Insert random rx_valid gaps into the good image: the written words and final state are unchanged.
  - Pulse rstn low after 5 bytes: all outputs return to their reset values. A following complete good image then loads correctly.
- Reload from DONE: pulse reload -> cpu_rstn=0 and done=0 the next cycle. A new image with N=1 (01 00 | 11 22 33 44 | 44) writes 0x44332211 to addr 0, then done=1.
